// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle for sync_fifo_flags: producer/consumer requests in, occupancy and error status out.
// master = the stage driving the FIFO, slave = the FIFO itself.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [PTR_WIDTH:0]    count;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output full, almost_full, rd_data, rd_valid, empty, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered flags, occupancy count and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_flags_if.slave bus
);
    localparam int DEPTH = 2 ** PTR_WIDTH;
    localparam int CW    = PTR_WIDTH + 1;

    typedef logic [CW-1:0] ptr_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t wr_ptr, rd_ptr;
    ptr_t wr_ptr_next, rd_ptr_next, count_next;
    ptr_t count_q;
    logic full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
    logic full_next, empty_next;
    logic wr_ok, rd_ok;

    // Acceptance uses the registered flags, i.e. the state seen at this edge.
    assign wr_ok = bus.wr_en && !full_q;
    assign rd_ok = bus.rd_en && !empty_q;

    // NOTE: every output of this block is assigned on every pass, so no latch is inferred;
    // combinational logic uses blocking '=' while the flops below use '<='.
    always_comb begin
        wr_ptr_next = wr_ptr + ptr_t'(wr_ok);
        rd_ptr_next = rd_ptr + ptr_t'(rd_ok);
        count_next  = wr_ptr_next - rd_ptr_next;
        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[PTR_WIDTH] != rd_ptr_next[PTR_WIDTH]) &&
                      (wr_ptr_next[PTR_WIDTH-1:0] == rd_ptr_next[PTR_WIDTH-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            count_q <= count_next;
            empty_q <= empty_next;
            full_q  <= full_next;
            ae_q    <= (count_next <= ptr_t'(AE_LEVEL));
            af_q    <= (count_next >= ptr_t'(AF_LEVEL));
            // A new error in the same cycle as err_clr keeps the flag set.
            if (bus.wr_en && full_q)      ovf_q <= 1'b1;
            else if (bus.err_clr)         ovf_q <= 1'b0;
            if (bus.rd_en && empty_q)     udf_q <= 1'b1;
            else if (bus.err_clr)         udf_q <= 1'b0;
        end
    end

    // NOTE: storage is deliberately not reset; only pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[PTR_WIDTH-1:0]] <= bus.wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.rd_data  = mem[rd_ptr[PTR_WIDTH-1:0]];
    assign bus.rd_valid = !empty_q;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) rd_data_q <= mem[rd_ptr[PTR_WIDTH-1:0]];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (DATA_WIDTH=8, PTR_WIDTH=4, AF=12, AE=4).
// Follows SYNC_FIFO_FWFT_EN so the same vectors cover both read modes.
module tb_sync_fifo_flags;
`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(8), .PTR_WIDTH(4)) bus ();

    sync_fifo_flags #(
        .DATA_WIDTH(8),
        .PTR_WIDTH (4),
        .AF_LEVEL  (12),
        .AE_LEVEL  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       rd_en;
        logic       err_clr;
        int         cnt;
        logic       ovf;
        logic       udf;
        logic       rv;
        logic [7:0] rd;
        logic       chk_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [7:0] wd, logic re, logic ec, int cnt,
                                logic ovf, logic udf, logic rv, logic [7:0] rd, logic chk_rd);
        vec_t v;
        v.wr_en = we; v.wr_data = wd; v.rd_en = re; v.err_clr = ec;
        v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.rv = rv; v.rd = rd; v.chk_rd = chk_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags are defined purely by occupancy, so one count implies the whole flag set.
    task automatic check_state(input string tag, input int cnt, input logic ovf, input logic udf);
        check({tag, " count"},        32'(bus.count),        32'(cnt));
        check({tag, " empty"},        32'(bus.empty),        32'(cnt == 0));
        check({tag, " full"},         32'(bus.full),         32'(cnt == 16));
        check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= 4));
        check({tag, " almost_full"},  32'(bus.almost_full),  32'(cnt >= 12));
        check({tag, " overflow"},     32'(bus.overflow),     32'(ovf));
        check({tag, " underflow"},    32'(bus.underflow),    32'(udf));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] wd, input logic re, input logic ec);
        bus.wr_en = we; bus.wr_data = wd; bus.rd_en = re; bus.err_clr = ec;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill 0x00..0x0F, one rejected write, drain, one rejected read, then clear errors.
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1'b1, 8'(i), 1'b0, 1'b0, i + 1, 1'b0, 1'b0, FWFT, 8'h00, 1'b1));
        vecs.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b0, 16, 1'b1, 1'b0, FWFT, 8'h00, 1'b1));
        for (int j = 0; j < 16; j++)
            vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 15 - j, 1'b1, 1'b0,
                              FWFT ? (j != 15) : 1'b1,
                              FWFT ? 8'(j + 1) : 8'(j),
                              FWFT ? (j != 15) : 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 8'h0F, !FWFT));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h0F, !FWFT));

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_state("reset", 0, 1'b0, 1'b0);
        check("reset rd_valid", 32'(bus.rd_valid), 32'd0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en, vecs[i].err_clr);
            step();
            check_state(tag, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
            check({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(vecs[i].rv));
            if (vecs[i].chk_rd)
                check({tag, " rd_data"}, 32'(bus.rd_data), 32'(vecs[i].rd));
        end

        // Ten words in, then 40 cycles of simultaneous push/pop across several wraps.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
            step();
        end
        check_state("wrap_fill", 10, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 8'(8'h2A + k), 1'b1, 1'b0);
            step();
            check($sformatf("wrap%0d count", k), 32'(bus.count), 32'd10);
            check($sformatf("wrap%0d rd_valid", k), 32'(bus.rd_valid), 32'd1);
            check($sformatf("wrap%0d rd_data", k), 32'(bus.rd_data),
                  32'(FWFT ? 8'(8'h21 + k) : 8'(8'h20 + k)));
        end

        // Top up to full, then push+pop at full: only the pop is taken.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
            step();
        end
        check_state("topup", 16, 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        step();
        check_state("wr_rd_full", 15, 1'b1, 1'b0);
        check("wr_rd_full rd_data", 32'(bus.rd_data), 32'(FWFT ? 8'h49 : 8'h48));

        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        check_state("err_clr", 15, 1'b0, 1'b0);
        drive(1'b1, 8'h70, 1'b0, 1'b0);
        step();
        check_state("refill", 16, 1'b0, 1'b0);
        drive(1'b1, 8'h71, 1'b0, 1'b1);
        step();
        check_state("clr_vs_set", 16, 1'b1, 1'b0);

        // Re-reset, reach count 7 with a pop in flight, then drop rst_n between edges.
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_state("rereset", 0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_state("pre_async", 7, 1'b0, 1'b0);
        check("pre_async rd_valid", 32'(bus.rd_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_state("async_rst", 0, 1'b0, 1'b0);
        check("async_rst rd_valid", 32'(bus.rd_valid), 32'd0);
        step();
        rst_n = 1'b1;

`ifdef SYNC_FIFO_FWFT_EN
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("fwft rd_valid", 32'(bus.rd_valid), 32'd1);
        check("fwft rd_data", 32'(bus.rd_data), 32'h5A);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_state("fwft_pop", 0, 1'b0, 1'b0);
        check("fwft_pop rd_valid", 32'(bus.rd_valid), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
